// File: rtl/fk_pkg.sv
// fk_pkg: shared types and constants for the SCARA forward-kinematics block.
// Holds the FSM state enum, CORDIC gain/angle constants and the arctangent table.
package fk_pkg;

    localparam int AW = 13;
    localparam int LW = 14;
    localparam int PW = 16;
    localparam int XW = 20;

    typedef logic signed [AW-1:0] angle_t;
    typedef logic [LW-1:0]        len_t;
    typedef logic signed [PW-1:0] pos_t;
    typedef logic signed [XW-1:0] dp_t;

    typedef enum logic [2:0] {
        IDLE,
        PREP1,
        ROT1,
        PREP2,
        ROT2,
        SUM
    } fk_state_e;

    // 1/K of the CORDIC rotator in Q14
    localparam logic [13:0] KINV_Q14 = 14'd9949;

    localparam int HALF_PI = 2048;
    localparam int PI      = 4096;

    // round(atan(2^-i) * 32768 / pi)
    function automatic logic signed [15:0] atan_lut(input int i);
        case (i)
            0:       return 16'sd8192;
            1:       return 16'sd4836;
            2:       return 16'sd2555;
            3:       return 16'sd1297;
            4:       return 16'sd651;
            5:       return 16'sd326;
            6:       return 16'sd163;
            7:       return 16'sd81;
            8:       return 16'sd41;
            9:       return 16'sd20;
            10:      return 16'sd10;
            11:      return 16'sd5;
            12:      return 16'sd3;
            13:      return 16'sd1;
            14:      return 16'sd1;
            default: return 16'sd0;
        endcase
    endfunction

endpackage

// File: rtl/forward_kinematics_if.sv
// forward_kinematics_if: request/result bundle of the forward-kinematics block.
// master drives enable/th1/th2/l1/l2; slave returns busy/dataReady/x/y.
interface forward_kinematics_if;
    import fk_pkg::*;

    logic   enable;
    angle_t th1;
    angle_t th2;
    len_t   l1;
    len_t   l2;
    logic   busy;
    logic   dataReady;
    pos_t   x;
    pos_t   y;

    modport master (
        output enable, th1, th2, l1, l2,
        input  busy, dataReady, x, y
    );

    modport slave (
        input  enable, th1, th2, l1, l2,
        output busy, dataReady, x, y
    );

endinterface

// File: rtl/cordic_rotate.sv
// cordic_rotate: folds the angle into +-pi/2, pre-scales radius by 1/K, then rotates.
// Ports: clk, reset (async low), start, angle, radius -> done pulse, xo/yo result.
module cordic_rotate
    import fk_pkg::*;
#(
    parameter int ITER  = 16,
    parameter int FRAC  = 2,
    parameter int AFRAC = 3
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   start,
    input  angle_t angle,
    input  len_t   radius,
    output logic   done,
    output dp_t    xo,
    output dp_t    yo
);

    localparam int CW = $clog2(ITER);
    localparam int ZW = AW + AFRAC;
    localparam int SH = 14 - FRAC;
    localparam logic [27:0] PRND = 28'(1) << (SH - 1);

    dp_t                  x_q, x_d, y_q, y_d;
    logic signed [ZW-1:0] z_q, z_d;
    logic [CW-1:0]        i_q, i_d;
    logic                 run_q, run_d;
    logic                 done_q, done_d;

    logic [27:0]          prod;
    logic signed [AW:0]   a_w;
    logic                 neg;
    dp_t                  x0, xs, ys;
    logic signed [ZW-1:0] z0, at;

    always_comb begin
        prod = 28'(radius) * 28'(KINV_Q14);
        x0   = XW'((prod + PRND) >> SH);
        a_w  = (AW+1)'(angle);
        neg  = 1'b0;
        // Fold into [-pi/2, pi/2]; the half-turn is absorbed by negating x0.
        if (a_w > (AW+1)'(HALF_PI)) begin
            a_w = a_w - (AW+1)'(PI);
            neg = 1'b1;
        end else if (a_w < -(AW+1)'(HALF_PI)) begin
            a_w = a_w + (AW+1)'(PI);
            neg = 1'b1;
        end
        if (neg) begin
            x0 = -x0;
        end
        z0 = ZW'(a_w) <<< AFRAC;

        xs = x_q >>> i_q;
        ys = y_q >>> i_q;
        at = ZW'(atan_lut(int'(i_q)));

        x_d    = x_q;
        y_d    = y_q;
        z_d    = z_q;
        i_d    = i_q;
        run_d  = run_q;
        done_d = 1'b0;

        if (start) begin
            x_d   = x0;
            y_d   = '0;
            z_d   = z0;
            i_d   = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            if (z_q[ZW-1]) begin
                x_d = x_q + ys;
                y_d = y_q - xs;
                z_d = z_q + at;
            end else begin
                x_d = x_q - ys;
                y_d = y_q + xs;
                z_d = z_q - at;
            end
            i_d = i_q + CW'(1);
            if (i_q == CW'(ITER - 1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            i_q    <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            z_q    <= z_d;
            i_q    <= i_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign xo   = x_q;
    assign yo   = y_q;

endmodule

// File: rtl/forward_kinematics.sv
// forward_kinematics: SCARA (th1, th2, l1, l2) -> (x, y) using one shared CORDIC.
// Ports: clk, reset (async low), bus (slave: enable/angles/lengths in, busy/dataReady/x/y out).
module forward_kinematics
    import fk_pkg::*;
#(
    parameter int ITER  = 16,
    parameter int FRAC  = 2,
    parameter int AFRAC = 3
) (
    input logic                 clk,
    input logic                 reset,
    forward_kinematics_if.slave bus
);

    localparam int CW = $clog2(ITER);
    localparam logic signed [XW:0] RHALF = (XW+1)'(1 << (FRAC - 1));
    localparam logic signed [XW:0] SMAX  = (XW+1)'(32767);
    localparam logic signed [XW:0] SMIN  = -(XW+1)'(32768);

    fk_state_e     state_q, state_d;
    angle_t        th1_q, th1_d, th2_q, th2_d;
    len_t          l1_q, l1_d, l2_q, l2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    dp_t           acc_x_q, acc_x_d, acc_y_q, acc_y_d;
    pos_t          x_q, x_d, y_q, y_d;
    logic          busy_q, busy_d;
    logic          rdy_q, rdy_d;

    logic          start, done;
    angle_t        angle;
    len_t          radius;
    dp_t           xo, yo;

    // Round half away from zero, drop FRAC bits, clamp to 16 bits.
    function automatic pos_t round_sat(input dp_t v);
        logic signed [XW:0] m;
        logic signed [XW:0] r;
        m = v[XW-1] ? -(XW+1)'(v) : (XW+1)'(v);
        r = (m + RHALF) >>> FRAC;
        if (v[XW-1]) begin
            r = -r;
        end
        if (r > SMAX) begin
            return 16'sh7fff;
        end
        if (r < SMIN) begin
            return 16'sh8000;
        end
        return PW'(r);
    endfunction

    cordic_rotate #(
        .ITER  (ITER),
        .FRAC  (FRAC),
        .AFRAC (AFRAC)
    ) u_rot (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .angle  (angle),
        .radius (radius),
        .done   (done),
        .xo     (xo),
        .yo     (yo)
    );

    always_comb begin
        state_d = state_q;
        th1_d   = th1_q;
        th2_d   = th2_q;
        l1_d    = l1_q;
        l2_d    = l2_q;
        cnt_d   = cnt_q;
        acc_x_d = acc_x_q;
        acc_y_d = acc_y_q;
        x_d     = x_q;
        y_d     = y_q;
        busy_d  = busy_q;
        rdy_d   = 1'b0;
        start   = 1'b0;
        angle   = th1_q;
        radius  = l1_q;

        unique case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    th1_d   = bus.th1;
                    th2_d   = bus.th2;
                    l1_d    = bus.l1;
                    l2_d    = bus.l2;
                    acc_x_d = '0;
                    acc_y_d = '0;
                    busy_d  = 1'b1;
                    state_d = PREP1;
                end
            end
            PREP1: begin
                start   = 1'b1;
                cnt_d   = '0;
                state_d = ROT1;
            end
            ROT1: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER - 1)) begin
                    state_d = PREP2;
                end
            end
            PREP2: begin
                // Rotation 1 result is stable here while rotation 2 is launched.
                start   = 1'b1;
                angle   = th1_q + th2_q;
                radius  = l2_q;
                acc_x_d = acc_x_q + xo;
                acc_y_d = acc_y_q + yo;
                state_d = ROT2;
            end
            ROT2: begin
                if (done) begin
                    acc_x_d = acc_x_q + xo;
                    acc_y_d = acc_y_q + yo;
                    state_d = SUM;
                end
            end
            SUM: begin
                x_d     = round_sat(acc_x_q);
                y_d     = round_sat(acc_y_q);
                busy_d  = 1'b0;
                rdy_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            th1_q   <= '0;
            th2_q   <= '0;
            l1_q    <= '0;
            l2_q    <= '0;
            cnt_q   <= '0;
            acc_x_q <= '0;
            acc_y_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            th1_q   <= th1_d;
            th2_q   <= th2_d;
            l1_q    <= l1_d;
            l2_q    <= l2_d;
            cnt_q   <= cnt_d;
            acc_x_q <= acc_x_d;
            acc_y_q <= acc_y_d;
            x_q     <= x_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.dataReady = rdy_q;
    assign bus.x         = x_q;
    assign bus.y         = y_q;

endmodule

// File: tb/tb_forward_kinematics.sv
// tb_forward_kinematics: vector table + trig model feeding a result scoreboard.
// Checks reset state, latency, busy/dataReady protocol and x/y within 2 LSB.
module tb_forward_kinematics;

    logic clk = 1'b0;
    logic reset;
    logic prev_rdy = 1'b0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int th1;
        int th2;
        int l1;
        int l2;
        int ex;
        int ey;
    } vec_t;

    typedef struct {
        int ex;
        int ey;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[6];

    forward_kinematics_if bus ();

    forward_kinematics dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int want, input int tol);
        int d;
        d = got - want;
        checks++;
        if (d > tol || d < -tol) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    function automatic int rnd(input real r);
        if (r >= 0.0) return $rtoi(r + 0.5);
        return -$rtoi(-r + 0.5);
    endfunction

    function automatic vec_t mk(input int t1, input int t2, input int a, input int b);
        real  k;
        real  xr;
        real  yr;
        int   s;
        vec_t v;
        k = 3.14159265358979 / 4096.0;
        s = t1 + t2;
        if (s >= 4096) s = s - 8192;
        else if (s < -4096) s = s + 8192;
        xr = real'(a) * $cos(real'(t1) * k) + real'(b) * $cos(real'(s) * k);
        yr = real'(a) * $sin(real'(t1) * k) + real'(b) * $sin(real'(s) * k);
        v = '{t1, t2, a, b, rnd(xr), rnd(yr)};
        return v;
    endfunction

    always @(negedge clk) begin
        if (reset && bus.dataReady) begin
            exp_t e;
            check("ready_width", int'(prev_rdy), 0, 0);
            check("busy_at_ready", int'(bus.busy), 0, 0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_ready got x=%0d y=%0d want none", bus.x, bus.y);
            end else begin
                e = sb.pop_front();
                check("x", int'(bus.x), e.ex, 2);
                check("y", int'(bus.y), e.ey, 2);
            end
        end
        prev_rdy <= bus.dataReady;
    end

    task automatic apply(input vec_t v, input bit push);
        bus.th1    = 13'(v.th1);
        bus.th2    = 13'(v.th2);
        bus.l1     = 14'(v.l1);
        bus.l2     = 14'(v.l2);
        bus.enable = 1'b1;
        if (push) sb.push_back('{v.ex, v.ey});
    endtask

    task automatic wait_done(input int hold, output int lat);
        lat = -1;
        @(posedge clk);
        @(negedge clk);
        check("busy_after_accept", int'(bus.busy), 1, 0);
        if (hold == 0) bus.enable = 1'b0;
        bus.th1 = 13'($urandom);
        bus.th2 = 13'($urandom);
        bus.l1  = 14'($urandom);
        bus.l2  = 14'($urandom);
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == hold) bus.enable = 1'b0;
            if (bus.dataReady) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_op(input vec_t v, input int hold, input string tag);
        int lat;
        apply(v, 1'b1);
        wait_done(hold, lat);
        check({tag, "_latency"}, lat, 36, 0);
    endtask

    initial begin
        reset      = 1'b0;
        bus.enable = 1'b0;
        bus.th1    = '0;
        bus.th2    = '0;
        bus.l1     = '0;
        bus.l2     = '0;

        tbl[0] = '{0, 0, 1000, 800, 1800, 0};
        tbl[1] = '{2048, 0, 1000, 800, 0, 1800};
        tbl[2] = '{0, 2048, 1000, 800, 1000, 800};
        tbl[3] = '{-4096, 0, 1000, 800, -1800, 0};
        tbl[4] = '{3072, 3072, 1000, 800, -707, -93};
        tbl[5] = '{0, 0, 16383, 16383, 32766, 0};

        repeat (3) @(negedge clk);
        check("rst_x", int'(bus.x), 0, 0);
        check("rst_y", int'(bus.y), 0, 0);
        check("rst_busy", int'(bus.busy), 0, 0);
        check("rst_ready", int'(bus.dataReady), 0, 0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_op(tbl[i], 0, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 6; i++) begin
            vec_t v;
            v = mk(int'($urandom_range(0, 8191)) - 4096,
                   int'($urandom_range(0, 8191)) - 4096,
                   int'($urandom_range(0, 1500)),
                   int'($urandom_range(0, 1500)));
            run_op(v, 0, $sformatf("rand%0d", i));
        end

        // enable held high through the whole operation
        run_op(tbl[5], 35, "hold");
        bus.enable = 1'b0;

        // reset partway through an operation
        @(negedge clk);
        apply(tbl[0], 1'b0);
        @(posedge clk);
        @(negedge clk);
        bus.enable = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_x", int'(bus.x), 0, 0);
        check("midrst_y", int'(bus.y), 0, 0);
        check("midrst_busy", int'(bus.busy), 0, 0);
        check("midrst_ready", int'(bus.dataReady), 0, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (45) @(negedge clk);
        check("idle_after_reset", int'(bus.busy), 0, 0);

        run_op(tbl[2], 0, "post_reset");
        bus.enable = 1'b0;

        repeat (5) @(negedge clk);
        check("sb_empty", sb.size(), 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
